core_run_controller: RTL and testbench
======================================

Name: core_run_controller

Overview:
Sequences one RISC_V_Core run, replacing hand-written reset/start/report stimulus.
- On a go request it holds the core in reset, latches the program start address and pulses start.
- It then counts run cycles until the core signals halt or a timeout expires, and pulses report.
- It sits between the host/test harness and the core's reset, start, prog_address and report pins.

Parameters:
ADDRESS_BITS, 20, width of program start address
RESET_CYCLES, 2, cycles core_reset is held after go is accepted (legal values >= 1)
COUNT_BITS, 32, width of run cycle counter
TIMEOUT, 1000000, run-cycle limit; 0 disables timeout

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low controller reset
go  in  1  run request, sampled in IDLE only
abort  in  1  cancel current run
go_address  in  ADDRESS_BITS  program start address, sampled with go
core_halt  in  1  core finished (tohost/ecall detect), sampled in RUN only
core_reset  out  1  reset to core, active-high
core_start  out  1  start pulse to core
core_prog_address  out  ADDRESS_BITS  start address to core
core_report  out  1  performance-report pulse to core
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
timed_out  out  1  status: last run ended by timeout
cycle_count  out  COUNT_BITS  run cycles of current/last run

Behaviour:
- States: IDLE, RESET_CORE, START, RUN, REPORT, DONE. Encoding is free.
- Reset asserted (reset=0), asynchronously:
  - state=IDLE, core_reset=1, core_start=0, core_report=0;
  - core_prog_address=0, busy=0, done=0, timed_out=0, cycle_count=0.
- IDLE:
  - core_reset=1.
  - On an edge with go=1 and abort=0:
    - latch go_address into core_prog_address;
    - clear cycle_count and timed_out;
    - go to RESET_CORE.
  - abort=1 blocks go.
- RESET_CORE:
  - core_reset=1 for exactly RESET_CYCLES cycles (internal counter), then START.
- START:
  - core_reset=0, core_start=1 for exactly one cycle, then RUN.
- RUN:
  - core_reset=0, core_start=0.
  - Every rising edge: cycle_count <= cycle_count+1, saturating at all-ones.
  - Exit priority on the same edge: abort > core_halt > timeout.
    - core_halt=1 -> REPORT, timed_out stays 0.
    - TIMEOUT!=0 and incremented count == TIMEOUT, no halt -> REPORT, timed_out <= 1.
  - Halt sampled in the first RUN cycle yields cycle_count=1.
- REPORT:
  - core_report=1 for one cycle; core_reset stays 0 so the core can dump counters; then DONE.
- DONE:
  - done=1 for one cycle, core_reset=0, then IDLE.
  - core_reset rises on entry to IDLE.
- abort=1 in RESET_CORE, START or RUN:
  - next state IDLE; no report, no done;
  - cycle_count frozen at its value on that edge (no increment); timed_out=0.
  - abort is ignored in REPORT and DONE.
- go outside IDLE is ignored and not queued. go held high in IDLE re-triggers a new run on the first IDLE cycle.
- core_prog_address is stable from acceptance through DONE and holds its last value in IDLE.
- cycle_count and timed_out hold until the next accepted go.
- Accepted-go edge to core_start high: RESET_CYCLES+1 cycles.
- Halt edge to done high: 2 cycles.
- Reset mid-run returns to IDLE immediately with core_reset=1.

Test Plan:
- Reset release, go=1 with go_address=0x00100, RESET_CYCLES=2 -> core_reset high 2 cycles after acceptance, core_start high exactly 1 cycle, core_prog_address=0x00100.
- After start, core_halt high on the 10th RUN cycle -> cycle_count=10, core_report 1 cycle, done 1 cycle later, timed_out=0, busy drops with return to IDLE.
- TIMEOUT=50, core_halt never asserted -> exit RUN with cycle_count=50, timed_out=1, core_report and done each pulse once.
- core_halt and timeout on the same edge (TIMEOUT=50, halt on cycle 50) -> timed_out=0, cycle_count=50.
- abort during RUN at cycle 7 -> IDLE next cycle, core_reset=1, no core_report/done, cycle_count=6; abort in REPORT -> ignored, done still pulses.
- Drive reset=0 mid-RUN (asynchronously, between edges) -> all outputs at reset values immediately; go pulsed while busy -> ignored, no second run.

Source files
------------

// File: rtl/core_run_controller.sv
// Run sequencer for one RISC-V core: holds the core in reset, starts it at a latched
// address, counts run cycles until halt/timeout/abort, then pulses report and done.
module core_run_controller #(
  parameter int ADDRESS_BITS = 20,
  parameter int RESET_CYCLES = 2,
  parameter int COUNT_BITS   = 32,
  parameter int TIMEOUT      = 1000000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    go,
  input  logic                    abort,
  input  logic [ADDRESS_BITS-1:0] go_address,
  input  logic                    core_halt,
  output logic                    core_reset,
  output logic                    core_start,
  output logic [ADDRESS_BITS-1:0] core_prog_address,
  output logic                    core_report,
  output logic                    busy,
  output logic                    done,
  output logic                    timed_out,
  output logic [COUNT_BITS-1:0]   cycle_count
);

  typedef enum logic [2:0] {
    IDLE,
    RESET_CORE,
    START,
    RUN,
    REPORT,
    DONE
  } state_e;

  localparam int RstW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RstW-1:0] RstLast = RstW'(RESET_CYCLES - 1);
  localparam logic [COUNT_BITS-1:0] TimeoutVal = COUNT_BITS'(TIMEOUT);

  state_e                  state_q, state_d;
  logic [RstW-1:0]         rstCnt_q, rstCnt_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [COUNT_BITS-1:0]   count_q, count_d;
  logic                    timedOut_q, timedOut_d;
  logic [COUNT_BITS-1:0]   countInc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rstCnt_q   <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      timedOut_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rstCnt_q   <= rstCnt_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      timedOut_q <= timedOut_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rstCnt_d   = rstCnt_q;
    addr_d     = addr_q;
    count_d    = count_q;
    timedOut_d = timedOut_q;
    // Saturating increment so a runaway run never wraps back to small counts
    countInc   = (&count_q) ? count_q : count_q + COUNT_BITS'(1);

    case (state_q)
      IDLE: begin
        if (go && !abort) begin
          addr_d     = go_address;
          count_d    = '0;
          timedOut_d = 1'b0;
          rstCnt_d   = '0;
          state_d    = RESET_CORE;
        end
      end
      RESET_CORE: begin
        if (abort) begin
          timedOut_d = 1'b0;
          state_d    = IDLE;
        end else if (rstCnt_q == RstLast) begin
          state_d = START;
        end else begin
          rstCnt_d = rstCnt_q + RstW'(1);
        end
      end
      START: begin
        if (abort) begin
          timedOut_d = 1'b0;
          state_d    = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort freezes the count; halt beats a timeout landing on the same edge
        if (abort) begin
          timedOut_d = 1'b0;
          state_d    = IDLE;
        end else begin
          count_d = countInc;
          if (core_halt) begin
            state_d = REPORT;
          end else if ((TIMEOUT != 0) && (countInc == TimeoutVal)) begin
            timedOut_d = 1'b1;
            state_d    = REPORT;
          end
        end
      end
      REPORT:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign core_reset        = (state_q == IDLE) || (state_q == RESET_CORE);
  assign core_start        = (state_q == START);
  assign core_report       = (state_q == REPORT);
  assign done              = (state_q == DONE);
  assign busy              = (state_q != IDLE);
  assign core_prog_address = addr_q;
  assign cycle_count       = count_q;
  assign timed_out         = timedOut_q;

endmodule

// File: tb/tb_core_run_controller.sv
// Self-checking bench for core_run_controller: directed runs plus randomized runs
// whose expected outcome is derived from halt/abort/timeout cycle numbers.
module tb_core_run_controller;

  localparam int AB = 20;
  localparam int RC = 2;
  localparam int CB = 32;
  localparam int TO = 50;
  localparam int NEVER = 1000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0;
  logic          abort = 1'b0;
  logic          coreHalt = 1'b0;
  logic [AB-1:0] goAddress = '0;
  logic          coreReset, coreStart, coreReport, busy, done, timedOut;
  logic [AB-1:0] coreProgAddress;
  logic [CB-1:0] cycleCount;

  int checks = 0;
  int errors = 0;

  logic [AB-1:0] lastAddr = '0;
  logic [CB-1:0] lastCount = '0;
  logic          lastTimedOut = 1'b0;

  core_run_controller #(
    .ADDRESS_BITS(AB),
    .RESET_CYCLES(RC),
    .COUNT_BITS(CB),
    .TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .go(go),
    .abort(abort),
    .go_address(goAddress),
    .core_halt(coreHalt),
    .core_reset(coreReset),
    .core_start(coreStart),
    .core_prog_address(coreProgAddress),
    .core_report(coreReport),
    .busy(busy),
    .done(done),
    .timed_out(timedOut),
    .cycle_count(cycleCount)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_core_reset"}, coreReset, 1'b1);
    checkOutput({tag, "_start"}, coreStart, 1'b0);
    checkOutput({tag, "_report"}, coreReport, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_addr"}, coreProgAddress, lastAddr);
    checkOutput({tag, "_count"}, cycleCount, lastCount);
    checkOutput({tag, "_timed_out"}, timedOut, lastTimedOut);
  endtask

  // One complete run; haltCycle/abortCycle are RUN-cycle numbers (abortCycle 0 = none)
  task automatic applyStimulus(input logic [AB-1:0] addr, input int haltCycle,
                               input int abortCycle, input bit abortInReport,
                               input bit goWhileBusy);
    int  stopCycle, endCycle, expCount;
    bit  aborted, expTimedOut;
    stopCycle   = (haltCycle < TO) ? haltCycle : TO;
    aborted     = (abortCycle != 0) && (abortCycle <= stopCycle);
    endCycle    = aborted ? abortCycle : stopCycle;
    expCount    = aborted ? abortCycle - 1 : stopCycle;
    expTimedOut = !aborted && (haltCycle > TO);

    go = 1'b1;
    goAddress = addr;
    tick();
    go = 1'b0;
    goAddress = AB'($urandom);
    lastAddr = addr;
    checkOutput("accept_busy", busy, 1'b1);
    checkOutput("accept_core_reset", coreReset, 1'b1);
    checkOutput("accept_start", coreStart, 1'b0);
    checkOutput("accept_addr", coreProgAddress, addr);
    checkOutput("accept_count", cycleCount, 0);
    checkOutput("accept_timed_out", timedOut, 1'b0);
    for (int i = 1; i < RC; i++) begin
      tick();
      checkOutput("rst_core_reset", coreReset, 1'b1);
      checkOutput("rst_start", coreStart, 1'b0);
    end
    tick();
    checkOutput("start_pulse", coreStart, 1'b1);
    checkOutput("start_core_reset", coreReset, 1'b0);
    checkOutput("start_addr", coreProgAddress, addr);

    go = goWhileBusy;
    tick();
    go = 1'b0;
    for (int k = 1; k <= endCycle; k++) begin
      coreHalt = (k == haltCycle);
      abort    = (k == abortCycle);
      tick();
      coreHalt = 1'b0;
      abort    = 1'b0;
      if (k < endCycle) begin
        checkOutput("run_count", cycleCount, k);
        checkOutput("run_report", coreReport, 1'b0);
        checkOutput("run_start", coreStart, 1'b0);
        checkOutput("run_core_reset", coreReset, 1'b0);
      end
    end

    if (aborted) begin
      lastCount = CB'(expCount);
      lastTimedOut = 1'b0;
      checkIdle("abort");
      tick();
      checkIdle("abort_hold");
    end else begin
      checkOutput("report_pulse", coreReport, 1'b1);
      checkOutput("report_done", done, 1'b0);
      checkOutput("report_core_reset", coreReset, 1'b0);
      checkOutput("report_busy", busy, 1'b1);
      checkOutput("report_count", cycleCount, expCount);
      checkOutput("report_timed_out", timedOut, expTimedOut);
      abort = abortInReport;
      tick();
      abort = 1'b0;
      checkOutput("done_pulse", done, 1'b1);
      checkOutput("done_report", coreReport, 1'b0);
      checkOutput("done_core_reset", coreReset, 1'b0);
      checkOutput("done_busy", busy, 1'b1);
      checkOutput("done_addr", coreProgAddress, addr);
      lastCount = CB'(expCount);
      lastTimedOut = expTimedOut;
      tick();
      checkIdle("after_done");
      tick();
      checkIdle("idle_hold");
    end
  endtask

  initial begin
    #1;
    checkIdle("reset");
    #3 reset = 1'b1;
    tick();
    checkIdle("post_reset");

    $display("[TB] directed runs");
    applyStimulus(20'h00100, 10, 0, 1'b0, 1'b0);
    applyStimulus(20'h12345, NEVER, 0, 1'b0, 1'b0);
    applyStimulus(20'hABCDE, TO, 0, 1'b0, 1'b0);
    applyStimulus(20'h00F00, 20, 7, 1'b0, 1'b0);
    applyStimulus(20'h55555, 5, 0, 1'b1, 1'b1);
    applyStimulus(20'hFFFFF, 1, 0, 1'b0, 1'b1);
    applyStimulus(20'h00001, 3, 3, 1'b0, 1'b0);

    go = 1'b1;
    abort = 1'b1;
    goAddress = 20'h77777;
    tick();
    go = 1'b0;
    abort = 1'b0;
    checkIdle("abort_blocks_go");

    $display("[TB] asynchronous reset mid-run");
    go = 1'b1;
    goAddress = 20'h2AAAA;
    tick();
    go = 1'b0;
    repeat (RC + 4) tick();
    checkOutput("pre_reset_busy", busy, 1'b1);
    checkOutput("pre_reset_count", cycleCount, 3);
    #3 reset = 1'b0;
    #1;
    lastAddr = '0;
    lastCount = '0;
    lastTimedOut = 1'b0;
    checkIdle("async_reset");
    #2 reset = 1'b1;
    tick();
    checkIdle("after_async_reset");

    $display("[TB] randomized runs");
    repeat (20) begin
      applyStimulus(AB'($urandom), $urandom_range(1, 60),
                    ($urandom_range(0, 3) == 0) ? $urandom_range(1, 55) : 0,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
